// File: rtl/hazard_flush_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a multi-cycle EX hold FSM,
// plus saturating stall/flush event counters for performance debug.
module hazard_flush_unit #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       IF_ID_Rs,
   input  logic [4:0]       IF_ID_Rt,
   input  logic             ID_uses_rt,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_Rt,
   input  logic             EX_branch_taken,
   input  logic             EX_mul_start,
   input  logic             clr_counters,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic             EX_hold,
   output logic             mul_done,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMulBusy = 2'd1
   } state_e;

   localparam logic [3:0]       BusyInit = 4'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax   = '1;

   state_e           state_q, state_d;
   logic [3:0]       busy_q, busy_d;
   logic             mul_done_q, mul_done_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             load_use;
   logic             stall_inc, flush_inc;

   assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                     ((ID_EX_Rt == IF_ID_Rs) || (ID_uses_rt && (ID_EX_Rt == IF_ID_Rt)));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StRun;
         busy_q     <= 4'd0;
         mul_done_q <= 1'b0;
         stall_q    <= '0;
         flush_q    <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         mul_done_q <= mul_done_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
      end
   end

   // Next-state and event generation
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      mul_done_d = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      case (state_q)
         StRun: begin
            // Branch outranks everything: the younger mul/load-use are wrong-path
            if (EX_branch_taken) begin
               flush_inc = 1'b1;
            end else if (EX_mul_start) begin
               stall_inc = 1'b1;
               busy_d    = BusyInit;
               state_d   = StMulBusy;
            end else if (load_use) begin
               stall_inc = 1'b1;
            end
         end
         StMulBusy: begin
            stall_inc = 1'b1;
            if (busy_q == 4'd1) begin
               state_d    = StRun;
               busy_d     = 4'd0;
               mul_done_d = 1'b1;
            end else begin
               busy_d = busy_q - 4'd1;
            end
         end
         default: begin
            state_d = StRun;
            busy_d  = 4'd0;
         end
      endcase

      if (clr_counters) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         stall_d = (stall_inc && (stall_q != CntMax)) ? stall_q + CntOne : stall_q;
         flush_d = (flush_inc && (flush_q != CntMax)) ? flush_q + CntOne : flush_q;
      end
   end

   // Control outputs
   always_comb begin
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
      flush_IF_ID = 1'b0;
      flush_ID_EX = 1'b0;
      EX_hold     = 1'b0;
      case (state_q)
         StRun: begin
            if (EX_branch_taken) begin
               flush_IF_ID = 1'b1;
               flush_ID_EX = 1'b1;
            end else if (EX_mul_start) begin
               PC_write    = 1'b0;
               IF_ID_write = 1'b0;
               EX_hold     = 1'b1;
            end else if (load_use) begin
               PC_write    = 1'b0;
               IF_ID_write = 1'b0;
               flush_ID_EX = 1'b1;
            end
         end
         StMulBusy: begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            EX_hold     = 1'b1;
         end
         default: ;
      endcase
   end

   assign mul_done    = mul_done_q;
   assign stall_count = stall_q;
   assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Directed bench for hazard_flush_unit (MUL_CYCLES=4, CNT_W=4 so saturation is reachable).
module tb_hazard_flush_unit;

   localparam int unsigned CntW = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [4:0]      IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
   logic            ID_uses_rt, ID_EX_MemRead, EX_branch_taken, EX_mul_start, clr_counters;
   logic            PC_write, IF_ID_write, flush_IF_ID, flush_ID_EX, EX_hold, mul_done;
   logic [CntW-1:0] stall_count, flush_count;

   int checks = 0;
   int errors = 0;

   hazard_flush_unit #(
      .MUL_CYCLES(4),
      .CNT_W     (CntW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .IF_ID_Rs       (IF_ID_Rs),
      .IF_ID_Rt       (IF_ID_Rt),
      .ID_uses_rt     (ID_uses_rt),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .ID_EX_Rt       (ID_EX_Rt),
      .EX_branch_taken(EX_branch_taken),
      .EX_mul_start   (EX_mul_start),
      .clr_counters   (clr_counters),
      .PC_write       (PC_write),
      .IF_ID_write    (IF_ID_write),
      .flush_IF_ID    (flush_IF_ID),
      .flush_ID_EX    (flush_ID_EX),
      .EX_hold        (EX_hold),
      .mul_done       (mul_done),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkc(input string tag, input logic [CntW-1:0] obs, input logic [CntW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // pc, ifid, fl_ifid, fl_idex, hold
   task automatic chk_ctl(input string tag, input logic pc, input logic ifid, input logic fi,
                          input logic fe, input logic hold);
      chk1({tag, ".PC_write"}, PC_write, pc);
      chk1({tag, ".IF_ID_write"}, IF_ID_write, ifid);
      chk1({tag, ".flush_IF_ID"}, flush_IF_ID, fi);
      chk1({tag, ".flush_ID_EX"}, flush_ID_EX, fe);
      chk1({tag, ".EX_hold"}, EX_hold, hold);
   endtask

   task automatic idle_inputs();
      IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_EX_Rt = 5'd0; ID_uses_rt = 1'b0;
      ID_EX_MemRead = 1'b0; EX_branch_taken = 1'b0; EX_mul_start = 1'b0; clr_counters = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      #1;
      chk_ctl("reset", 1, 1, 0, 0, 0);
      chkc("reset.stall_count", stall_count, 4'd0);
      chkc("reset.flush_count", flush_count, 4'd0);
      chk1("reset.mul_done", mul_done, 1'b0);
      tick();

      // Load-use on rs
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5;
      #1 chk_ctl("lu_rs", 0, 0, 0, 1, 0);
      tick();
      idle_inputs();
      #1 chkc("lu_rs.stall_count", stall_count, 4'd1);
      chk_ctl("lu_rs.after", 1, 1, 0, 0, 0);

      // $zero destination never stalls
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
      #1 chk_ctl("lu_r0", 1, 1, 0, 0, 0);
      tick();
      chkc("lu_r0.stall_count", stall_count, 4'd1);

      // rt match only matters when ID reads rt
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd7; IF_ID_Rt = 5'd7; IF_ID_Rs = 5'd3; ID_uses_rt = 1'b0;
      #1 chk_ctl("lu_rt_unused", 1, 1, 0, 0, 0);
      ID_uses_rt = 1'b1;
      #1 chk_ctl("lu_rt_used", 0, 0, 0, 1, 0);
      tick();
      idle_inputs();
      #1 chkc("lu_rt.stall_count", stall_count, 4'd2);

      // Branch beats load-use
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd9; EX_branch_taken = 1'b1;
      #1 chk_ctl("br_lu", 1, 1, 1, 1, 0);
      tick();
      idle_inputs();
      #1 chkc("br_lu.flush_count", flush_count, 4'd1);
      chkc("br_lu.stall_count", stall_count, 4'd2);

      // Multi-cycle op: 4 hold cycles, mul_done on the 5th
      EX_mul_start = 1'b1;
      #1 chk_ctl("mul.c1", 0, 0, 0, 0, 1);
      chk1("mul.c1.done", mul_done, 1'b0);
      tick();
      EX_mul_start = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         EX_branch_taken = (i == 3);
         #1 chk_ctl($sformatf("mul.c%0d", i), 0, 0, 0, 0, 1);
         chk1($sformatf("mul.c%0d.done", i), mul_done, 1'b0);
         tick();
      end
      idle_inputs();
      #1 chk_ctl("mul.c5", 1, 1, 0, 0, 0);
      chk1("mul.c5.done", mul_done, 1'b1);
      chkc("mul.stall_count", stall_count, 4'd6);
      chkc("mul.flush_count", flush_count, 4'd1);
      tick();
      chk1("mul.c6.done", mul_done, 1'b0);

      // Reset in the 2nd MUL_BUSY cycle
      EX_mul_start = 1'b1;
      tick();
      EX_mul_start = 1'b0;
      tick();
      #1 chk1("mrst.busy_hold", EX_hold, 1'b1);
      reset_n = 1'b0;
      #1 chk_ctl("mrst", 1, 1, 0, 0, 0);
      chkc("mrst.stall_count", stall_count, 4'd0);
      chkc("mrst.flush_count", flush_count, 4'd0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1($sformatf("mrst.nodone%0d", i), mul_done, 1'b0);
         chk1($sformatf("mrst.nohold%0d", i), EX_hold, 1'b0);
      end

      // Saturation after 20 stalls, then clear beats increment
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd4; IF_ID_Rs = 5'd4;
      repeat (14) tick();
      chkc("sat.14", stall_count, 4'd14);
      repeat (6) tick();
      chkc("sat.20", stall_count, 4'd15);
      clr_counters = 1'b1;
      #1 chk_ctl("clr.stall_ctl", 0, 0, 0, 1, 0);
      tick();
      chkc("clr.stall_count", stall_count, 4'd0);
      clr_counters = 1'b0;
      tick();
      chkc("clr.resume", stall_count, 4'd1);
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

endmodule
